// File: rtl/hyp_seq_128b_pkg.sv
// Shared constants and FSM state type for the sequential hypotenuse block.
package hyp_seq_pkg;

  localparam int WIDTH_DEF = 128;
  localparam int ITER      = WIDTH_DEF + 1;
  localparam int LATENCY   = WIDTH_DEF + 3;

  typedef enum logic [1:0] {
    IDLE,
    SUM,
    ROOT,
    DONE
  } state_t;

endpackage

// File: rtl/hyp_seq_128b_if.sv
// Operand/result handshake bundle for hyp_seq_128b; master drives operands, slave computes.
import hyp_seq_pkg::*;

interface hyp_seq_128b_if #(
  parameter int WIDTH = WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out0;
  logic             out_ovf;

  modport master (
    output in_valid, in0, in1, out_ready,
    input  in_ready, out_valid, out0, out_ovf
  );

  modport slave (
    input  in_valid, in0, in1, out_ready,
    output in_ready, out_valid, out0, out_ovf
  );

endinterface

// File: rtl/hyp_seq_128b_step.sv
// One radix-2 restoring square-root digit step: shifts in two radicand bits, decides one root bit.
import hyp_seq_pkg::*;

module hyp_sqrt_step #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH+2:0] rem,
  input  logic [WIDTH:0]   root,
  input  logic [1:0]       bits,
  output logic [WIDTH+2:0] rem_next,
  output logic [WIDTH:0]   root_next
);

  logic [WIDTH+4:0] rem_t;
  logic [WIDTH+4:0] trial;
  logic             ge;

  // Trial subtrahend is 4*root+1; the remainder never exceeds 2*root so the truncations are lossless.
  assign rem_t     = {rem, bits};
  assign trial     = {2'b00, root, 2'b01};
  assign ge        = (rem_t >= trial);
  assign rem_next  = ge ? (WIDTH+3)'(rem_t - trial) : (WIDTH+3)'(rem_t);
  assign root_next = (WIDTH+1)'({root, ge});

endmodule

// File: rtl/hyp_seq_128b.sv
// Sequential floor(sqrt(a*a+b*b)) with valid/ready handshakes.
// Optional round-to-nearest result when HYP_SEQ_ROUND_EN is defined.
import hyp_seq_pkg::*;

module hyp_seq_128b #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  hyp_seq_128b_if.slave bus
);

  localparam int RAD_W = 2 * WIDTH + 2;
  localparam int REM_W = WIDTH + 3;
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH + 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a, b;
  logic [RAD_W-1:0]   rad;
  logic [REM_W-1:0]   rem, rem_nxt;
  logic [WIDTH:0]     root, root_nxt, res;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   out0_r;
  logic               ovf_r;
  logic [RAD_W-1:0]   a_ext, b_ext;

  assign a_ext = RAD_W'(a);
  assign b_ext = RAD_W'(b);

  hyp_sqrt_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem),
    .root      (root),
    .bits      (rad[RAD_W-1 -: 2]),
    .rem_next  (rem_nxt),
    .root_next (root_nxt)
  );

`ifdef HYP_SEQ_ROUND_EN
  // Nearest integer: sqrt(x) >= q+0.5 exactly when the remainder x-q*q exceeds q.
  assign res = (rem > REM_W'(root)) ? root + {{WIDTH{1'b0}}, 1'b1} : root;
`else
  assign res = root;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = SUM;
      end
      SUM:  state_nxt = ROOT;
      ROOT: if (cnt == LAST) state_nxt = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ROOT spends WIDTH+1 cycles stepping, then one more cycle latching the result into the output regs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a      <= '0;
      b      <= '0;
      rad    <= '0;
      rem    <= '0;
      root   <= '0;
      cnt    <= '0;
      out0_r <= '0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a <= bus.in0;
            b <= bus.in1;
          end
        end
        SUM: begin
          rad  <= a_ext * a_ext + b_ext * b_ext;
          rem  <= '0;
          root <= '0;
          cnt  <= '0;
        end
        ROOT: begin
          if (cnt == LAST) begin
            out0_r <= res[WIDTH-1:0];
            ovf_r  <= res[WIDTH];
          end else begin
            rad  <= rad << 2;
            rem  <= rem_nxt;
            root <= root_nxt;
            cnt  <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out0    = out0_r;
  assign bus.out_ovf = ovf_r;

endmodule
